// File: rtl/gat_layer_scheduler_if.sv
// Host/core-facing signal bundle for the GAT layer scheduler.
// The master side drives commands and load pulses; the scheduler is the slave.
interface gat_layer_scheduler_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 start;
    logic                 abort;
    logic                 h_data_load_pulse;
    logic                 h_node_info_load_pulse;
    logic                 wgt_load_pulse;
    logic                 gat_ready;
    logic                 h_data_bram_load_done;
    logic                 h_node_info_bram_load_done;
    logic                 wgt_bram_load_done;
    logic                 gat_layer;
    logic                 sched_busy;
    logic                 sched_irq;
    logic [31:0]          sched_status;
    logic [CNT_WIDTH-1:0] layer_cycles;

    modport master (
        output start, abort, h_data_load_pulse, h_node_info_load_pulse,
               wgt_load_pulse, gat_ready,
        input  h_data_bram_load_done, h_node_info_bram_load_done,
               wgt_bram_load_done, gat_layer, sched_busy, sched_irq,
               sched_status, layer_cycles
    );

    modport slave (
        input  start, abort, h_data_load_pulse, h_node_info_load_pulse,
               wgt_load_pulse, gat_ready,
        output h_data_bram_load_done, h_node_info_bram_load_done,
               wgt_bram_load_done, gat_layer, sched_busy, sched_irq,
               sched_status, layer_cycles
    );
endinterface

// File: rtl/gat_layer_scheduler.sv
// Two-layer GAT inference sequencer: gathers BRAM load pulses, drives the
// core's load-done levels and layer select, and detects completion/timeout.
module gat_layer_scheduler #(
    parameter int TIMEOUT_CYCLES = 2**24,
    parameter int CNT_WIDTH      = 32
) (
    input logic                  clk,
    input logic                  rst,
    gat_layer_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT0 = 3'd1,
        RUN0  = 3'd2,
        WAIT1 = 3'd3,
        RUN1  = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t               state, state_n;
    logic                 hd_f, ni_f, wg_f, armed, layer, err;
    logic                 hd_n, ni_n, wg_n, armed_n, layer_n, err_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n, lc, lc_n;
    logic                 hd_done, ni_done, wg_done, busy, irq;
    logic                 in_run, run_n, complete;

    assign in_run   = (state == RUN0) || (state == RUN1);
    // armed is the registered value, so ready-high in the arming cycle itself never completes
    assign complete = in_run && bus.gat_ready && armed;
    assign run_n    = (state_n == RUN0) || (state_n == RUN1);

    always_comb begin
        state_n = state;
        hd_n    = hd_f;
        ni_n    = ni_f;
        wg_n    = wg_f;
        armed_n = armed;
        layer_n = layer;
        err_n   = err;
        cnt_n   = cnt;
        lc_n    = lc;

        if (!in_run) begin
            if (bus.h_data_load_pulse)      hd_n = 1'b1;
            if (bus.h_node_info_load_pulse) ni_n = 1'b1;
            if (bus.wgt_load_pulse)         wg_n = 1'b1;
        end

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = WAIT0;
                    err_n   = 1'b0;
                end
            end
            WAIT0: begin
                if (hd_f && ni_f && wg_f) state_n = RUN0;
            end
            RUN0, RUN1: begin
                if (!bus.gat_ready) armed_n = 1'b1;
                // completion outranks the timeout when both land on the last count
                if (complete) begin
                    lc_n    = cnt;
                    cnt_n   = '0;
                    armed_n = 1'b0;
                    if (state == RUN0) begin
                        wg_n    = 1'b0;
                        layer_n = 1'b1;
                        state_n = WAIT1;
                    end else begin
                        state_n = DONE;
                    end
                end else if (cnt == CNT_LAST) begin
                    lc_n    = CNT_LAST;
                    cnt_n   = '0;
                    armed_n = 1'b0;
                    err_n   = 1'b1;
                    state_n = ERR;
                end else begin
                    cnt_n = cnt + CNT_WIDTH'(1);
                end
            end
            WAIT1: begin
                if (wg_f) state_n = RUN1;
            end
            DONE, ERR: begin
                if (bus.start) begin
                    wg_n    = 1'b0;
                    layer_n = 1'b0;
                    state_n = WAIT0;
                end
            end
            default: state_n = IDLE;
        endcase

        if (bus.abort) begin
            state_n = IDLE;
            hd_n    = 1'b0;
            ni_n    = 1'b0;
            wg_n    = 1'b0;
            armed_n = 1'b0;
            layer_n = 1'b0;
            cnt_n   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            hd_f    <= 1'b0;
            ni_f    <= 1'b0;
            wg_f    <= 1'b0;
            armed   <= 1'b0;
            layer   <= 1'b0;
            err     <= 1'b0;
            cnt     <= '0;
            lc      <= '0;
            hd_done <= 1'b0;
            ni_done <= 1'b0;
            wg_done <= 1'b0;
            busy    <= 1'b0;
            irq     <= 1'b0;
        end else begin
            state   <= state_n;
            hd_f    <= hd_n;
            ni_f    <= ni_n;
            wg_f    <= wg_n;
            armed   <= armed_n;
            layer   <= layer_n;
            err     <= err_n;
            cnt     <= cnt_n;
            lc      <= lc_n;
            hd_done <= run_n && hd_n;
            ni_done <= run_n && ni_n;
            wg_done <= run_n && wg_n;
            busy    <= !((state_n == IDLE) || (state_n == DONE) || (state_n == ERR));
            irq     <= ((state_n == DONE) || (state_n == ERR)) && (state_n != state);
        end
    end

    assign bus.h_data_bram_load_done      = hd_done;
    assign bus.h_node_info_bram_load_done = ni_done;
    assign bus.wgt_bram_load_done         = wg_done;
    assign bus.gat_layer                  = layer;
    assign bus.sched_busy                 = busy;
    assign bus.sched_irq                  = irq;
    assign bus.sched_status               = {27'd0, layer, err, state};
    assign bus.layer_cycles               = lc;
endmodule

// File: tb/tb_gat_layer_scheduler.sv
// Directed bench: vector table for the basic flow, hand sequences for the
// long run, timeout and last-count corners (short-timeout instance b).
module tb_gat_layer_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, abort = 1'b0, hd = 1'b0, ni = 1'b0, wg = 1'b0, rdy = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    gat_layer_scheduler_if #(.CNT_WIDTH(32)) ifa ();
    gat_layer_scheduler_if #(.CNT_WIDTH(32)) ifb ();

    assign ifa.start = start;
    assign ifa.abort = abort;
    assign ifa.h_data_load_pulse = hd;
    assign ifa.h_node_info_load_pulse = ni;
    assign ifa.wgt_load_pulse = wg;
    assign ifa.gat_ready = rdy;
    assign ifb.start = start;
    assign ifb.abort = abort;
    assign ifb.h_data_load_pulse = hd;
    assign ifb.h_node_info_load_pulse = ni;
    assign ifb.wgt_load_pulse = wg;
    assign ifb.gat_ready = rdy;

    gat_layer_scheduler #(.TIMEOUT_CYCLES(256), .CNT_WIDTH(32)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave));
    gat_layer_scheduler #(.TIMEOUT_CYCLES(16), .CNT_WIDTH(32)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave));

    typedef struct packed {
        logic       st, ab, h, n, w, r;
        logic [2:0] state;
        logic [2:0] dones;
        logic       layer, busy, irq;
        logic [7:0] lc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic s, logic a, logic h, logic n, logic w, logic r,
                                logic [2:0] stv, logic [2:0] d, logic l, logic b,
                                logic i, logic [7:0] c);
        vec_t v;
        v.st = s; v.ab = a; v.h = h; v.n = n; v.w = w; v.r = r;
        v.state = stv; v.dones = d; v.layer = l; v.busy = b; v.irq = i; v.lc = c;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc(input logic s, input logic a, input logic h, input logic n,
                       input logic w, input logic r);
        @(negedge clk);
        start = s; abort = a; hd = h; ni = n; wg = w; rdy = r;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [69:0] snap_a();
        return {ifa.sched_status, ifa.h_data_bram_load_done, ifa.h_node_info_bram_load_done,
                ifa.wgt_bram_load_done, ifa.gat_layer, ifa.sched_busy, ifa.sched_irq,
                ifa.layer_cycles};
    endfunction

    // Abort, load all three BRAMs, start: instance b sits in RUN0 cycle index 0.
    task automatic b_to_run0();
        cyc(0, 1, 0, 0, 0, 1);
        cyc(0, 0, 1, 1, 1, 1);
        cyc(1, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("b_enter_run0", 128'(ifb.sched_status[2:0]), 128'd2);
    endtask

    initial begin
        int irq_cnt;
        vec_t v;
        logic [69:0] exp;

        // st ab hd ni wg rdy | state dones layer busy irq lc
        vq.push_back(mk(0,0,1,0,0,1, 0,3'b000,0,0,0,0));
        vq.push_back(mk(0,0,0,1,0,1, 0,3'b000,0,0,0,0));
        vq.push_back(mk(1,0,0,0,0,1, 1,3'b000,0,1,0,0));
        vq.push_back(mk(0,0,0,0,0,1, 1,3'b000,0,1,0,0));
        vq.push_back(mk(0,0,0,0,1,1, 1,3'b000,0,1,0,0));
        vq.push_back(mk(0,0,0,0,0,1, 2,3'b111,0,1,0,0));
        vq.push_back(mk(0,0,0,0,0,0, 2,3'b111,0,1,0,0));
        vq.push_back(mk(0,0,0,0,0,0, 2,3'b111,0,1,0,0));
        vq.push_back(mk(0,0,0,0,0,1, 3,3'b000,1,1,0,2));
        vq.push_back(mk(0,0,0,0,1,1, 3,3'b000,1,1,0,2));
        vq.push_back(mk(0,0,0,0,0,1, 4,3'b111,1,1,0,2));
        vq.push_back(mk(0,0,0,0,0,0, 4,3'b111,1,1,0,2));
        vq.push_back(mk(0,0,0,0,0,1, 5,3'b000,1,0,1,1));
        vq.push_back(mk(0,0,0,0,0,1, 5,3'b000,1,0,0,1));
        vq.push_back(mk(1,0,0,0,0,1, 1,3'b000,0,1,0,1));
        vq.push_back(mk(0,0,0,0,1,1, 1,3'b000,0,1,0,1));
        vq.push_back(mk(0,0,0,0,0,1, 2,3'b111,0,1,0,1));
        vq.push_back(mk(1,0,0,0,0,1, 2,3'b111,0,1,0,1));
        vq.push_back(mk(0,0,0,0,1,0, 2,3'b111,0,1,0,1));
        vq.push_back(mk(0,0,0,0,0,1, 3,3'b000,1,1,0,2));
        vq.push_back(mk(0,0,0,0,0,1, 3,3'b000,1,1,0,2));
        vq.push_back(mk(0,0,0,0,0,1, 3,3'b000,1,1,0,2));
        vq.push_back(mk(0,0,0,0,1,1, 3,3'b000,1,1,0,2));
        vq.push_back(mk(0,0,0,0,0,1, 4,3'b111,1,1,0,2));
        vq.push_back(mk(0,1,0,0,0,1, 0,3'b000,0,0,0,2));
        vq.push_back(mk(1,0,0,0,0,1, 1,3'b000,0,1,0,2));
        vq.push_back(mk(0,0,0,0,0,1, 1,3'b000,0,1,0,2));
        vq.push_back(mk(0,0,1,0,0,1, 1,3'b000,0,1,0,2));
        vq.push_back(mk(0,0,0,1,0,1, 1,3'b000,0,1,0,2));
        vq.push_back(mk(0,0,0,0,1,1, 1,3'b000,0,1,0,2));
        vq.push_back(mk(0,0,0,0,0,1, 2,3'b111,0,1,0,2));
        vq.push_back(mk(1,1,0,0,0,1, 0,3'b000,0,0,0,2));

        repeat (2) @(posedge clk);
        #1;
        chk("reset_a", 128'(snap_a()), 128'd0);
        chk("reset_b_status", 128'(ifb.sched_status), 128'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[i]) begin
            v = vq[i];
            cyc(v.st, v.ab, v.h, v.n, v.w, v.r);
            exp = {27'd0, v.layer, 1'b0, v.state, v.dones, v.layer, v.busy, v.irq, 24'd0, v.lc};
            chk($sformatf("vec%0d", i), 128'(snap_a()), 128'(exp));
        end

        // Full two-layer run, ready low for 100 cycles per layer.
        cyc(0, 0, 1, 1, 1, 1);
        cyc(1, 0, 0, 0, 0, 1);
        chk("full_wait0", 128'(ifa.sched_status[2:0]), 128'd1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("full_run0", 128'({ifa.sched_status[2:0], ifa.h_data_bram_load_done,
                               ifa.h_node_info_bram_load_done, ifa.wgt_bram_load_done}),
            128'({3'd2, 3'b111}));
        for (int i = 0; i < 100; i++) cyc(0, 0, 0, 0, 0, 0);
        chk("full_run0_hold", 128'(ifa.sched_status[2:0]), 128'd2);
        cyc(0, 0, 0, 0, 0, 1);
        chk("full_wait1", 128'({ifa.sched_status[2:0], ifa.gat_layer, ifa.wgt_bram_load_done,
                                ifa.layer_cycles}), 128'({3'd3, 1'b1, 1'b0, 32'd100}));
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("full_run1", 128'({ifa.sched_status[2:0], ifa.wgt_bram_load_done}), 128'({3'd4, 1'b1}));
        irq_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            irq_cnt += int'(ifa.sched_irq);
        end
        cyc(0, 0, 0, 0, 0, 1);
        irq_cnt += int'(ifa.sched_irq);
        chk("full_done", 128'({ifa.sched_status, ifa.layer_cycles}), 128'({32'h15, 32'd100}));
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 1);
            irq_cnt += int'(ifa.sched_irq);
        end
        chk("full_irq_once", 128'(irq_cnt), 128'd1);
        cyc(1, 1, 0, 0, 0, 1);
        chk("done_start_abort", 128'({ifa.sched_status, ifa.sched_busy, ifa.h_data_bram_load_done,
                                      ifa.h_node_info_bram_load_done, ifa.wgt_bram_load_done}),
            128'd0);

        // Timeout with ready held low.
        b_to_run0();
        for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, 0, 0);
        chk("to_last_still_run", 128'(ifb.sched_status[2:0]), 128'd2);
        cyc(0, 0, 0, 0, 0, 0);
        chk("to_err", 128'({ifb.sched_status, ifb.layer_cycles, ifb.h_data_bram_load_done,
                            ifb.h_node_info_bram_load_done, ifb.wgt_bram_load_done,
                            ifb.sched_irq, ifb.sched_busy}),
            128'({32'h0E, 32'd15, 3'b000, 1'b1, 1'b0}));

        // Completion on the last count beats the timeout.
        b_to_run0();
        for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("last_count_complete", 128'({ifb.sched_status, ifb.layer_cycles}),
            128'({32'h13, 32'd15}));

        // Ready never low in RUN0: never armed, so it times out.
        b_to_run0();
        for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, 0, 1);
        chk("unarmed_still_run", 128'(ifb.sched_status[2:0]), 128'd2);
        cyc(0, 0, 0, 0, 0, 1);
        chk("unarmed_timeout", 128'({ifb.sched_status, ifb.layer_cycles}),
            128'({32'h0E, 32'd15}));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
